// File: rtl/uart_rx_frame_if.sv
// Port bundle for the UART frame receiver: line, bit-rate tick and word format in,
// received word and status flags out.
interface uart_rx_frame_if;
  logic       rx_tick;
  logic       rxd;
  logic [1:0] WLS;
  logic       PEN;
  logic       EPS;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       framing_err;
  logic       break_int;
  logic       rx_busy;

  modport master (
    output rx_tick, rxd, WLS, PEN, EPS,
    input  rx_data, rx_valid, parity_err, framing_err, break_int, rx_busy
  );

  modport slave (
    input  rx_tick, rxd, WLS, PEN, EPS,
    output rx_data, rx_valid, parity_err, framing_err, break_int, rx_busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART frame receiver: 16x oversampled start/data/parity/stop decoding with
// parity, framing and break detection on a registered result interface.
//
//   state  | meaning
//   IDLE   | line idle, waiting for a synchronized low on an rx_tick
//   START  | validating the start bit at its midpoint (tick count 7)
//   DATA   | sampling data bits at tick count 15, LSB first
//   PARITY | sampling the parity bit at tick count 15
//   STOP   | sampling the first stop bit, then result is published
module uart_rx_frame (
  input  logic           clk,
  input  logic           rst,
  uart_rx_frame_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;

  logic       rxd_meta;
  logic       rxd_sync;

  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [2:0] last_bit;
  logic       pen_l;
  logic       eps_l;

  logic [7:0] data_reg;
  logic       par_acc;
  logic       par_err;
  logic       all_zero;

  logic       cnt_clr;
  logic       latch_cfg;
  logic       sample_data;
  logic       sample_par;
  logic       sample_stop;

  // Line is idle high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= bus.rxd;
      rxd_sync <= rxd_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    cnt_clr     = 1'b0;
    latch_cfg   = 1'b0;
    sample_data = 1'b0;
    sample_par  = 1'b0;
    sample_stop = 1'b0;
    if (bus.rx_tick) begin
      unique case (state)
        IDLE: begin
          if (!rxd_sync) begin
            state_next = START;
            cnt_clr    = 1'b1;
          end
        end
        START: begin
          if (tick_cnt == 4'd7) begin
            cnt_clr = 1'b1;
            if (rxd_sync) begin
              state_next = IDLE;
            end else begin
              state_next = DATA;
              latch_cfg  = 1'b1;
            end
          end
        end
        DATA: begin
          if (tick_cnt == 4'd15) begin
            sample_data = 1'b1;
            if (bit_cnt == last_bit) begin
              state_next = pen_l ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (tick_cnt == 4'd15) begin
            sample_par = 1'b1;
            state_next = STOP;
          end
        end
        STOP: begin
          if (tick_cnt == 4'd15) begin
            sample_stop = 1'b1;
            state_next  = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Bit-time counter wraps 15 -> 0 by itself, so only frame entry clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= 4'd0;
    end else if (bus.rx_tick) begin
      if (cnt_clr) begin
        tick_cnt <= 4'd0;
      end else if (state != IDLE) begin
        tick_cnt <= tick_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= 3'd0;
      last_bit <= 3'd0;
      pen_l    <= 1'b0;
      eps_l    <= 1'b0;
      data_reg <= 8'd0;
      par_acc  <= 1'b0;
      par_err  <= 1'b0;
      all_zero <= 1'b0;
    end else begin
      if (latch_cfg) begin
        bit_cnt  <= 3'd0;
        last_bit <= 3'd4 + {1'b0, bus.WLS};
        pen_l    <= bus.PEN;
        eps_l    <= bus.EPS;
        data_reg <= 8'd0;
        par_acc  <= 1'b0;
        par_err  <= 1'b0;
        all_zero <= 1'b1;
      end
      if (sample_data) begin
        bit_cnt           <= bit_cnt + 3'd1;
        data_reg[bit_cnt] <= rxd_sync;
        par_acc           <= par_acc ^ rxd_sync;
        all_zero          <= all_zero & ~rxd_sync;
      end
      if (sample_par) begin
        par_err  <= rxd_sync ^ (eps_l ? par_acc : ~par_acc);
        all_zero <= all_zero & ~rxd_sync;
      end
    end
  end

  // Results are published one clk after the stop-bit tick and held until the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rx_data     <= 8'd0;
      bus.rx_valid    <= 1'b0;
      bus.parity_err  <= 1'b0;
      bus.framing_err <= 1'b0;
      bus.break_int   <= 1'b0;
      bus.rx_busy     <= 1'b0;
    end else begin
      bus.rx_valid <= sample_stop;
      bus.rx_busy  <= (state_next != IDLE);
      if (sample_stop) begin
        bus.rx_data     <= data_reg;
        bus.parity_err  <= par_err;
        bus.framing_err <= ~rxd_sync;
        bus.break_int   <= all_zero & ~rxd_sync;
      end
    end
  end

endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset; all outputs SHALL be registered.
REQ-002 clk  input  1  system clock, 50 MHz nominal.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 rx_tick  input  1  one-clk enable pulse at 16x the baud rate.
REQ-005 rxd  input  1  serial line, idle high, asynchronous to clk.
REQ-006 WLS  input  2  word length: 00=5, 01=6, 10=7, 11=8 data bits.
REQ-007 PEN  input  1  1 = a parity bit follows the data bits.
REQ-008 EPS  input  1  1 = even parity, 0 = odd parity.
REQ-009 rx_data  output  8  received word, LSB first on the line; bits above the word length are 0.
REQ-010 rx_valid  output  1  one-clk pulse; rx_data and the error flags are valid in the same cycle.
REQ-011 parity_err  output  1  parity mismatch for the word in rx_data.
REQ-012 framing_err  output  1  first stop bit sampled low.
REQ-013 break_int  output  1  start, data, parity and stop bits were all sampled 0.
REQ-014 rx_busy  output  1  high in every state except IDLE.

Function
REQ-015 rxd SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-016 All state and counter updates SHALL occur only in clk cycles with rx_tick=1, except the rx_valid clear.
REQ-017 The FSM SHALL have five states: IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE -> START: on an rx_tick cycle with synchronized rxd=0; the 4-bit tick counter clears to 0.
REQ-019 START: at tick count 7 (mid-bit), rxd=0 -> DATA, counter cleared; rxd=1 -> IDLE (false start, no rx_valid).
REQ-020 WLS, PEN and EPS SHALL be latched on the START -> DATA transition; changes later in the frame SHALL be ignored.
REQ-021 DATA: at every 16th tick (count 15) one bit SHALL be sampled into bit position n (n = 0..len-1). After bit len-1 the FSM goes to PARITY if PEN=1, else to STOP.
REQ-022 PARITY: sample at count 15. Expected bit = XOR of the len data bits if EPS=1, its inverse if EPS=0; a mismatch sets parity_err.
REQ-023 STOP: sample at count 15; rxd=0 sets framing_err. The FSM then returns to IDLE, and rx_valid pulses in the next clk cycle.
REQ-024 Only the first stop bit SHALL be checked; a second stop bit is treated as idle line.
REQ-025 break_int SHALL be 1 when the data bits, the parity bit (if enabled) and the stop bit all sampled 0; framing_err is also 1 in that case.
REQ-026 rx_data and the three flags SHALL update only together with rx_valid and hold until the next rx_valid.
REQ-027 rx_valid SHALL be high for exactly one clk cycle per completed frame.
REQ-028 The FSM SHALL re-arm in IDLE in the same rx_tick cycle, so back-to-back frames with a single stop bit are received without loss.
REQ-029 Parity is not checked when PEN=0: parity_err SHALL be 0.

Reset
REQ-030 On rst=1 all outputs SHALL go to 0, the FSM to IDLE, the counters to 0 and the synchronizer flops to 1, immediately and independent of clk.
REQ-031 Reset mid-frame SHALL abandon the frame: no rx_valid; the next frame is received normally after rst deasserts.

Verification
REQ-032 8N1 frame of 0xA5, 16 ticks/bit -> one rx_valid pulse; rx_data=0xA5; all flags 0.
REQ-033 WLS=00, PEN=1, EPS=1, data 5'b10110 with parity bit 1 -> rx_data=0x16, parity_err=0; same frame with parity bit 0 -> parity_err=1.
REQ-034 8N1 frame 0x3C with stop bit driven 0 -> rx_data=0x3C, framing_err=1, break_int=0.
REQ-035 rxd held 0 for 12 bit times, then 1 -> rx_data=0x00, framing_err=1, break_int=1.
REQ-036 rxd low glitch of 4 ticks -> FSM returns to IDLE, rx_busy drops, no rx_valid.
REQ-037 rst asserted at data bit 3 of a frame, released, then 8E1 frame 0x81 sent -> exactly one rx_valid; rx_data=0x81; parity_err=0.
